// File: rtl/planet_regfile_if.sv
// Bus bundle between the physics FSM / host bus slave (master) and planet_regfile (slave).
interface planet_regfile_if;
  logic [1:0]  FSM_re;
  logic [1:0]  FSM_we;
  logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
  logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
  logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;
  logic        clear_accs;
  logic        FSM_DONE;
  logic [31:0] G;
  logic [31:0] PLANET_NUM;
  logic        FSM_START;
  logic [6:0]  host_addr;
  logic        host_we;
  logic        host_re;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_wait;
  logic        busy;
  logic        err;

  modport master (
    output FSM_re, FSM_we, ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
           DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, clear_accs, FSM_DONE,
           host_addr, host_we, host_re, host_wdata,
    input  DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in,
           G, PLANET_NUM, FSM_START, host_rdata, host_wait, busy, err
  );

  modport slave (
    input  FSM_re, FSM_we, ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
           DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, clear_accs, FSM_DONE,
           host_addr, host_we, host_re, host_wdata,
    output DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in,
           G, PLANET_NUM, FSM_START, host_rdata, host_wait, busy, err
  );
endinterface

// File: rtl/planet_regfile.sv
// Word store shared by the physics FSM (two 3-address lanes) and the host port, with start/done control.
// Optional address bounds checking and sticky err: define PLANET_REGFILE_BOUNDS_EN.
module planet_regfile #(
  parameter int unsigned DEPTH     = 114,
  parameter int unsigned ACC_BASE  = 84,
  parameter int unsigned ACC_WORDS = 30
) (
  input  logic             CLK,
  input  logic             RESET_N,
  planet_regfile_if.slave  bus
);

  localparam int unsigned AW    = 7;
  localparam int unsigned NPORT = 6;
  localparam int unsigned SLOTS = 1 << AW;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q;
  logic                   fsm_start_q;
  logic                   done_q;
  logic                   start_pend_q;
  logic                   busy;
  logic [NPORT-1:0][31:0] fsm_addr;
  logic [NPORT-1:0][31:0] fsm_data;
  logic [NPORT-1:0][31:0] data_in_q;
  logic [NPORT-1:0][AW-1:0] fsm_idx;
  logic [NPORT-1:0]       fsm_ok;
  logic [NPORT-1:0]       lane_re;
  logic [NPORT-1:0]       lane_we;
  logic                   host_ok;
  logic                   host_store;
  logic                   start_req;
  logic                   done_clr;
  logic [31:0]            host_rdata_q;
  logic [31:0]            rd_word [SLOTS];

  assign fsm_addr = {bus.ADDR6, bus.ADDR5, bus.ADDR4, bus.ADDR3, bus.ADDR2, bus.ADDR1};
  assign fsm_data = {bus.DATA6, bus.DATA5, bus.DATA4, bus.DATA3, bus.DATA2, bus.DATA1};
  assign lane_re  = {{3{bus.FSM_re[1]}}, {3{bus.FSM_re[0]}}};
  assign lane_we  = {{3{bus.FSM_we[1]}}, {3{bus.FSM_we[0]}}};

  always_comb begin
    for (int p = 0; p < NPORT; p++) fsm_idx[p] = fsm_addr[p][AW-1:0];
  end

`ifdef PLANET_REGFILE_BOUNDS_EN
  logic err_q;

  always_comb begin
    for (int p = 0; p < NPORT; p++) fsm_ok[p] = (fsm_addr[p] < 32'(DEPTH));
  end
  assign host_ok = (bus.host_addr < AW'(DEPTH));

  // Sticky flag for any enabled access that falls outside the map
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 1'b0;
    end else if ((|((lane_re | lane_we) & ~fsm_ok)) ||
                 ((bus.host_we || bus.host_re) && !host_ok)) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  logic unused_addr_hi;

  assign fsm_ok  = '1;
  assign host_ok = 1'b1;
  assign bus.err = 1'b0;
  assign unused_addr_hi = ^{bus.ADDR1[31:AW], bus.ADDR2[31:AW], bus.ADDR3[31:AW],
                            bus.ADDR4[31:AW], bus.ADDR5[31:AW], bus.ADDR6[31:AW]};
`endif

  assign busy       = (state_q == S_RUN);
  assign host_store = bus.host_we && !busy && host_ok;
  assign start_req  = bus.host_we && (bus.host_addr == AW'(2)) && (|bus.host_wdata);
  assign done_clr   = bus.host_we && (bus.host_addr == AW'(3)) && host_ok;
  assign bus.host_wait = bus.host_we && busy &&
                         (bus.host_addr != AW'(2)) && (bus.host_addr != AW'(3));

  // One register per word; priority host < lane1 < ... < lane6 < clear_accs
  for (genvar w = 0; w < SLOTS; w++) begin : g_word
    if (w >= DEPTH) begin : g_pad
      assign rd_word[w] = '0;
    end else if (w == 2) begin : g_start
      assign rd_word[w] = '0;
    end else if (w == 3) begin : g_done
      assign rd_word[w] = {31'b0, done_q};
    end else begin : g_store
      localparam bit IS_ACC = (w >= ACC_BASE) && (w < ACC_BASE + ACC_WORDS);
      logic [31:0] q;
      logic [31:0] d;
      logic        en;

      always_comb begin
        en = 1'b0;
        d  = bus.host_wdata;
        if (host_store && (bus.host_addr == AW'(w))) en = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
          if (lane_we[p] && fsm_ok[p] && (fsm_idx[p] == AW'(w))) begin
            en = 1'b1;
            d  = fsm_data[p];
          end
        end
        if (IS_ACC && bus.clear_accs) begin
          en = 1'b1;
          d  = '0;
        end
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  q <= '0;
        else if (en)   q <= d;
      end

      assign rd_word[w] = q;
    end
  end

  // Registered reads see pre-write contents
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_in_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (lane_re[p]) data_in_q[p] <= fsm_ok[p] ? rd_word[fsm_idx[p]] : 32'h0;
      end
      if (bus.host_re) host_rdata_q <= host_ok ? rd_word[bus.host_addr] : 32'h0;
    end
  end

  // Start/done control; a start coinciding with FSM_DONE is replayed next cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      fsm_start_q  <= 1'b0;
      done_q       <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      fsm_start_q <= 1'b0;
      if (done_clr) done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_req || start_pend_q) begin
            state_q      <= S_RUN;
            fsm_start_q  <= 1'b1;
            done_q       <= 1'b0;
            start_pend_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.FSM_DONE) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            start_pend_q <= start_req;
          end
        end
      endcase
    end
  end

  assign bus.DATA1in    = data_in_q[0];
  assign bus.DATA2in    = data_in_q[1];
  assign bus.DATA3in    = data_in_q[2];
  assign bus.DATA4in    = data_in_q[3];
  assign bus.DATA5in    = data_in_q[4];
  assign bus.DATA6in    = data_in_q[5];
  assign bus.host_rdata = host_rdata_q;
  assign bus.G          = rd_word[0];
  assign bus.PLANET_NUM = rd_word[1];
  assign bus.FSM_START  = fsm_start_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_planet_regfile.sv
// Scoreboard bench for planet_regfile: FSM lanes, host port, start/done control, clear_accs, reset.
module tb_planet_regfile;

  localparam int unsigned DEPTH = 114;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  planet_regfile_if bus ();
  planet_regfile dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  typedef struct {
    int          lane;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [128];
  logic        done_m;
  logic        busy_m;
  logic [31:0] fa [6];
  logic [31:0] fd [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [6:0] i;
    i = a[6:0];
`ifdef PLANET_REGFILE_BOUNDS_EN
    if (a >= DEPTH) return 32'h0;
`endif
    if (i >= DEPTH) return 32'h0;
    if (i == 7'd2)  return 32'h0;
    if (i == 7'd3)  return {31'b0, done_m};
    return mem_m[i];
  endfunction

  function automatic void m_wr(input logic [31:0] a, input logic [31:0] d);
    logic [6:0] i;
    i = a[6:0];
`ifdef PLANET_REGFILE_BOUNDS_EN
    if (a >= DEPTH) return;
`endif
    if (i < DEPTH && i != 7'd2 && i != 7'd3) mem_m[i] = d;
  endfunction

  function automatic logic [31:0] lane_out(input int l);
    case (l)
      0:       return bus.DATA1in;
      1:       return bus.DATA2in;
      2:       return bus.DATA3in;
      3:       return bus.DATA4in;
      4:       return bus.DATA5in;
      5:       return bus.DATA6in;
      default: return bus.host_rdata;
    endcase
  endfunction

  task automatic drain(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s_lane%0d", tag, e.lane), lane_out(e.lane), e.exp);
    end
  endtask

  task automatic fsm_op(input string tag, input logic [1:0] we, input logic [1:0] re, input logic clr);
    bus.ADDR1 = fa[0]; bus.ADDR2 = fa[1]; bus.ADDR3 = fa[2];
    bus.ADDR4 = fa[3]; bus.ADDR5 = fa[4]; bus.ADDR6 = fa[5];
    bus.DATA1 = fd[0]; bus.DATA2 = fd[1]; bus.DATA3 = fd[2];
    bus.DATA4 = fd[3]; bus.DATA5 = fd[4]; bus.DATA6 = fd[5];
    bus.FSM_we = we;
    bus.FSM_re = re;
    bus.clear_accs = clr;
    for (int p = 0; p < 6; p++) if (re[p/3]) sb_q.push_back('{p, m_rd(fa[p])});
    for (int p = 0; p < 6; p++) if (we[p/3]) m_wr(fa[p], fd[p]);
    if (clr) for (int i = 84; i < 114; i++) mem_m[i] = 32'h0;
    @(negedge CLK);
    bus.FSM_we = 2'b00;
    bus.FSM_re = 2'b00;
    bus.clear_accs = 1'b0;
    drain(tag);
  endtask

  task automatic host_read(input logic [6:0] a);
    bus.host_re = 1'b1;
    bus.host_addr = a;
    sb_q.push_back('{6, m_rd(32'(a))});
    @(negedge CLK);
    bus.host_re = 1'b0;
    drain($sformatf("hrd%0d", a));
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
    bus.host_we = 1'b1;
    bus.host_addr = a;
    bus.host_wdata = d;
    if (!busy_m) m_wr(32'(a), d);
    if (a == 7'd3) done_m = 1'b0;
    @(negedge CLK);
    bus.host_we = 1'b0;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 128; i++) mem_m[i] = 32'h0;
    done_m = 1'b0;
    busy_m = 1'b0;
  endtask

  initial begin
    bus.FSM_re = '0; bus.FSM_we = '0; bus.clear_accs = 1'b0; bus.FSM_DONE = 1'b0;
    bus.ADDR1 = '0; bus.ADDR2 = '0; bus.ADDR3 = '0; bus.ADDR4 = '0; bus.ADDR5 = '0; bus.ADDR6 = '0;
    bus.DATA1 = '0; bus.DATA2 = '0; bus.DATA3 = '0; bus.DATA4 = '0; bus.DATA5 = '0; bus.DATA6 = '0;
    bus.host_addr = '0; bus.host_we = 1'b0; bus.host_re = 1'b0; bus.host_wdata = '0;
    model_reset();
    RESET_N = 1'b0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_start", 32'(bus.FSM_START), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_data1in", bus.DATA1in, 32'h0);
    check("rst_hrdata", bus.host_rdata, 32'h0);
    check("rst_g", bus.G, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Host loads G and planet count
    host_wr(7'd0, 32'h4120_0000);
    check("g_out", bus.G, 32'h4120_0000);
    host_wr(7'd1, 32'd4);
    check("pnum_out", bus.PLANET_NUM, 32'd4);
    host_read(7'd0);
    host_read(7'd1);

    // Both lanes write, then read back
    fa = '{32'd24, 32'd25, 32'd26, 32'd100, 32'd101, 32'd104};
    fd = '{32'h3f80_0000, 32'h11, 32'h22, 32'h33, 32'h44, 32'hbf80_0000};
    fsm_op("wr2", 2'b11, 2'b00, 1'b0);
    fsm_op("rd2", 2'b00, 2'b11, 1'b0);

    // Collision: higher lane wins; read-during-write returns old data
    fa = '{32'd31, 32'd30, 32'd32, 32'd33, 32'd30, 32'd34};
    fd = '{32'd5, 32'd1, 32'd6, 32'd7, 32'd2, 32'd8};
    fsm_op("coll", 2'b11, 2'b00, 1'b0);
    fa = '{32'd30, 32'd31, 32'd32, 32'd33, 32'd34, 32'd0};
    fd = '{32'd9, 32'd15, 32'd16, 32'd0, 32'd0, 32'd0};
    fsm_op("rdw", 2'b01, 2'b01, 1'b0);
    fsm_op("rdw_after", 2'b00, 2'b11, 1'b0);

    // FSM_DONE while idle is ignored
    bus.FSM_DONE = 1'b1;
    @(negedge CLK);
    bus.FSM_DONE = 1'b0;
    host_read(7'd3);

    // Start pulse and busy
    host_wr(7'd2, 32'd1);
    busy_m = 1'b1;
    check("start_pulse", 32'(bus.FSM_START), 32'h1);
    check("busy_set", 32'(bus.busy), 32'h1);
    @(negedge CLK);
    check("start_single", 32'(bus.FSM_START), 32'h0);
    host_read(7'd2);

    // Start write during run is dropped without waiting
    bus.host_we = 1'b1; bus.host_addr = 7'd2; bus.host_wdata = 32'd1;
    #1 check("wait_word2", 32'(bus.host_wait), 32'h0);
    @(negedge CLK);
    bus.host_we = 1'b0;
    check("no_restart", 32'(bus.FSM_START), 32'h0);

    // Stalled host write completes after FSM_DONE
    bus.host_we = 1'b1; bus.host_addr = 7'd40; bus.host_wdata = 32'hcafe_0040;
    #1 check("wait_busy", 32'(bus.host_wait), 32'h1);
    @(negedge CLK);
    check("wait_hold", 32'(bus.host_wait), 32'h1);
    bus.FSM_DONE = 1'b1;
    @(negedge CLK);
    bus.FSM_DONE = 1'b0;
    check("busy_clr", 32'(bus.busy), 32'h0);
    check("wait_clr", 32'(bus.host_wait), 32'h0);
    @(negedge CLK);
    bus.host_we = 1'b0;
    busy_m = 1'b0;
    done_m = 1'b1;
    mem_m[40] = 32'hcafe_0040;
    host_read(7'd3);
    host_read(7'd40);
    host_wr(7'd3, 32'd0);
    host_read(7'd3);

    // Start coinciding with FSM_DONE is accepted the cycle after
    host_wr(7'd2, 32'd1);
    @(negedge CLK);
    bus.FSM_DONE = 1'b1;
    bus.host_we = 1'b1; bus.host_addr = 7'd2; bus.host_wdata = 32'd1;
    @(negedge CLK);
    bus.FSM_DONE = 1'b0;
    bus.host_we = 1'b0;
    check("dn_st_busy0", 32'(bus.busy), 32'h0);
    check("dn_st_start0", 32'(bus.FSM_START), 32'h0);
    @(negedge CLK);
    check("dn_st_start1", 32'(bus.FSM_START), 32'h1);
    check("dn_st_busy1", 32'(bus.busy), 32'h1);
    bus.FSM_DONE = 1'b1;
    @(negedge CLK);
    bus.FSM_DONE = 1'b0;
    done_m = 1'b1;
    busy_m = 1'b0;

    // clear_accs overrides a same-cycle FSM write
    for (int i = 84; i < 114; i++) host_wr(7'(i), 32'h3f80_0000);
    host_wr(7'd83, 32'h1234_5678);
    fa = '{32'd90, 32'd90, 32'd90, 32'd0, 32'd0, 32'd0};
    fd = '{32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0};
    fsm_op("clr", 2'b01, 2'b00, 1'b1);
    for (int i = 83; i < 114; i++) host_read(7'(i));

    // Out-of-map FSM address on lane 3
    check("err_before", 32'(bus.err), 32'h0);
    fa = '{32'd24, 32'd25, 32'd120, 32'd0, 32'd0, 32'd0};
    fd = '{32'h0000_1111, 32'h0000_2222, 32'hdead_beef, 32'd0, 32'd0, 32'd0};
    fsm_op("oob", 2'b01, 2'b01, 1'b0);
`ifdef PLANET_REGFILE_BOUNDS_EN
    check("err_after", 32'(bus.err), 32'h1);
`else
    check("err_after", 32'(bus.err), 32'h0);
`endif

    // Asynchronous reset in the middle of a run
    fa = '{32'd24, 32'd24, 32'd24, 32'd24, 32'd24, 32'd24};
    fsm_op("pre_rst", 2'b00, 2'b11, 1'b0);
    host_wr(7'd2, 32'd1);
    check("run_start", 32'(bus.FSM_START), 32'h1);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_busy", 32'(bus.busy), 32'h0);
    check("mid_start", 32'(bus.FSM_START), 32'h0);
    check("mid_err", 32'(bus.err), 32'h0);
    check("mid_g", bus.G, 32'h0);
    for (int l = 0; l < 6; l++) check($sformatf("mid_datain%0d", l + 1), lane_out(l), 32'h0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    host_read(7'd24);
    host_read(7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/planet_regfile.md
Name: planet_regfile

Overview:
- Responder end of the physics FSM memory interface: the word-addressed store the FSM reads and writes through its two 3-address lanes (ADDR1-3/DATA1-3, ADDR4-6/DATA4-6).
- Also exposes a host (software/bus) port that loads G, planet count and planet state, kicks FSM_START and observes completion.
- Sits between the host bus slave and the FSM, and replaces the behavioural store used in simulation.

Parameters:
- DEPTH, 114, number of 32-bit words. Map: 0 G, 1 NUM, 2 START, 3 DONE, 4-13 mass, 14-23 radius, 24-53 position X/Y/Z, 54-83 velocity X/Y/Z, 84-113 acceleration X/Y/Z. Planet i uses base-1+i, i=1..10.
- ACC_BASE, 84, first word cleared by clear_accs.
- ACC_WORDS, 30, number of words cleared by clear_accs.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- FSM_re  in  2  read lane enable: bit0 = lane A (1-3), bit1 = lane B (4-6)
- FSM_we  in  2  write lane enable, same encoding as FSM_re
- ADDR1..ADDR6  in  32 each  FSM word addresses
- DATA1..DATA6  in  32 each  FSM write data
- clear_accs  in  1  zero the acceleration words
- FSM_DONE  in  1  FSM completion pulse
- DATA1in..DATA6in  out  32 each  registered read data to the FSM
- G  out  32  word 0, driven continuously
- PLANET_NUM  out  32  word 1, driven continuously
- FSM_START  out  1  one-cycle start pulse
- host_addr  in  7  host word address
- host_we  in  1  host write strobe
- host_re  in  1  host read strobe
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data
- host_wait  out  1  host write stalled
- busy  out  1  FSM run in progress
- err  out  1  sticky out-of-range flag

Behaviour:
- Reset (RESET_N low, asynchronous): all words, all DATAnin outputs, host_rdata, FSM_START, busy and err are 0.
- FSM read: one-cycle latency. If a lane's FSM_re bit is set at edge k, that lane's DATAnin carries mem[ADDRn] after edge k. Lanes not enabled hold their last value.
- Read-during-write to the same address returns the pre-write contents.
- FSM write: an enabled lane writes at the edge.
- Address collision in one cycle: higher port number wins (ADDR6 over ADDR5 over ... over ADDR1).
- clear_accs: at the edge, words ACC_BASE..ACC_BASE+ACC_WORDS-1 become 0. Overrides any FSM or host write to those words in the same cycle.
- Host read: host_rdata = mem[host_addr] one cycle after host_re; otherwise holds its last value. Word 3 reads as the done latch.
- Host write when busy=0: writes at the edge, with host_wait=0.
- Host write when busy=1: host_wait=1 (combinational) and the write is stalled, with two exceptions that are always accepted:
  - A write to word 3 clears the done latch.
  - A write to word 2 is dropped, with host_wait=0.
- Same address, same cycle: FSM write wins over host write.
- Start, as a state machine IDLE -> RUN -> IDLE:
  - IDLE: a host write of a nonzero value to word 2 -> next cycle FSM_START=1 for exactly one cycle, busy=1, done latch=0. Word 2 reads back 0 at all times.
  - RUN: FSM_DONE=1 -> next edge busy=0, done latch=1, state IDLE.
  - FSM_DONE while in IDLE is ignored.
  - Host start write in the same cycle as FSM_DONE: the done is processed first, then start is accepted on the following cycle.
- Reset mid-run: returns to IDLE with busy=0, FSM_START=0 and memory zeroed.

Optional Feature:
- PLANET_REGFILE_BOUNDS_EN defined:
  - Any enabled FSM address >= DEPTH: that port's write is suppressed, and its read returns 0.
  - Any host address >= DEPTH: same handling.
  - Either case sets err (sticky until reset).
- Undefined:
  - Addresses are truncated to the low 7 bits.
  - Writes to truncated indices >= DEPTH are dropped.
  - Reads of truncated indices >= DEPTH return 0.
  - err is tied to 0.

Test Plan:
1. Host writes word 0=0x41200000 and word 1=4 -> G=0x41200000 and PLANET_NUM=4 on the next cycle. Host reads of words 0 and 1 return the same values after one cycle.
2. FSM_we=3 with ADDR1=24, DATA1=0x3f800000, ADDR6=104, DATA6=0xbf800000; next cycle FSM_re=3 with the same addresses -> DATA1in=0x3f800000 and DATA6in=0xbf800000 one cycle later. DATA2in-DATA5in show their addressed words.
3. FSM_we=3 with ADDR2=ADDR5=30, DATA2=1, DATA5=2 -> word 30 reads 2. Read and write of word 30 in the same cycle returns the old value.
4. Host writes word 2=1 -> FSM_START high for exactly one cycle and busy=1. Host write to word 40 stalls with host_wait=1. FSM_DONE pulse -> busy=0 and word 3 reads 1; the stalled write then completes. Host writes word 3=0 -> word 3 reads 0.
5. Words 84-113 preloaded with 0x3f800000; clear_accs=1 in the same cycle as an FSM write of 5 to word 90 -> all 30 words read 0, and word 83 is unchanged.
6. RESET_N dropped asynchronously mid-run -> busy=0, FSM_START=0, all DATAnin=0 immediately.
   - With PLANET_REGFILE_BOUNDS_EN: ADDR3=120 write plus read -> no write, DATA3in=0, err=1.
